// File: rtl/mc_control_pkg.sv
// mc_control_pkg: opcodes, func codes, FSM states and control encodings
// shared by the multicycle controller and its instruction decoder.
package mc_control_pkg;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_SUB = 6'd1;
    localparam logic [5:0] FN_AND = 6'd2;
    localparam logic [5:0] FN_ORR = 6'd3;
    localparam logic [5:0] FN_NOT = 6'd4;
    localparam logic [5:0] FN_TCP = 6'd5;
    localparam logic [5:0] FN_SHL = 6'd6;
    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [1:0] PCS_PC1    = 2'd0;
    localparam logic [1:0] PCS_BRANCH = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_REG    = 2'd3;

    localparam logic [1:0] ALUB_REG = 2'd0;
    localparam logic [1:0] ALUB_IMM = 2'd1;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_R2 = 2'd2;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic lwd;
        logic swd;
        logic branch;
        logic jmp;
        logic jal;
        logic jpr;
        logic jrl;
        logic hlt;
        logic nop;
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: classifies the instruction word into one-hot instruction
// classes; WWD and every undefined opcode/func fall into the nop class.
module mc_decode
    import mc_control_pkg::*;
#(
    parameter int WORD_SIZE = 16
) (
    input  logic [WORD_SIZE-1:0] i_inst,
    output iclass_t              o_cls
);

    logic [3:0] w_op;
    logic [5:0] w_fn;
    logic       w_unused_fields;

    assign w_op = i_inst[WORD_SIZE-1 -: 4];
    assign w_fn = i_inst[5:0];
    assign w_unused_fields = ^i_inst[WORD_SIZE-5:6];

    // one-hot class lookup on opcode, then func for R-type
    always_comb begin
        o_cls = '0;
        unique case (w_op)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: o_cls.branch = 1'b1;
            OP_ADI, OP_ORI, OP_LHI:         o_cls.alu_i  = 1'b1;
            OP_LWD:                         o_cls.lwd    = 1'b1;
            OP_SWD:                         o_cls.swd    = 1'b1;
            OP_JMP:                         o_cls.jmp    = 1'b1;
            OP_JAL:                         o_cls.jal    = 1'b1;
            OP_RTYPE: begin
                unique case (w_fn)
                    FN_ADD, FN_SUB, FN_AND, FN_ORR,
                    FN_NOT, FN_TCP, FN_SHL, FN_SHR: o_cls.alu_r = 1'b1;
                    FN_JPR:  o_cls.jpr = 1'b1;
                    FN_JRL:  o_cls.jrl = 1'b1;
                    FN_HLT:  o_cls.hlt = 1'b1;
                    default: o_cls.nop = 1'b1;
                endcase
            end
            default: o_cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle IF/ID/EX/MEM/WB controller with HALT state.
// Build option MC_CONTROL_NUM_INST_EN adds the num_inst retire counter.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int WORD_SIZE      = 16,
    parameter int FETCH_WAIT_MAX = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic                 mem_ready,
    input  logic                 bcond,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_source,
    output logic [1:0]           reg_dest,
    output logic                 is_halted,
    output logic                 inst_done,
`ifdef MC_CONTROL_NUM_INST_EN
    output logic [WORD_SIZE-1:0] num_inst,
`endif
    output logic                 fetch_timeout
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_wait;
    logic [31:0] w_wait_nxt;
    iclass_t     w_cls;
    logic        w_timeout;

    mc_decode #(.WORD_SIZE(WORD_SIZE)) u_dec (
        .i_inst (inst),
        .o_cls  (w_cls)
    );

    assign w_timeout = (FETCH_WAIT_MAX > 0) &&
                       (r_wait == 32'(FETCH_WAIT_MAX - 1));

    // state and IF wait counter; reset abandons any pending access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IF;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_nxt;
        end
    end

    // next state and Mealy outputs; everything reads 0 while in reset
    always_comb begin
        w_next        = r_state;
        w_wait_nxt    = '0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        pc_source     = PCS_PC1;
        reg_dest      = RDST_RT;
        is_halted     = 1'b0;
        inst_done     = 1'b0;
        fetch_timeout = 1'b0;
        if (reset_n) begin
            unique case (r_state)
                S_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        w_next   = S_ID;
                    end else if (w_timeout) begin
                        fetch_timeout = 1'b1;
                        w_next        = S_HALT;
                    end else begin
                        w_wait_nxt = r_wait + 32'd1;
                    end
                end
                S_ID: begin
                    if (w_cls.jmp || w_cls.jal ||
                        w_cls.jpr || w_cls.jrl) begin
                        pc_write  = 1'b1;
                        pc_source = (w_cls.jmp || w_cls.jal) ?
                                    PCS_JUMP : PCS_REG;
                        reg_write = w_cls.jal || w_cls.jrl;
                        reg_dest  = (w_cls.jal || w_cls.jrl) ?
                                    RDST_R2 : RDST_RT;
                        inst_done = 1'b1;
                        w_next    = S_IF;
                    end else if (w_cls.hlt) begin
                        inst_done = 1'b1;
                        w_next    = S_HALT;
                    end else if (w_cls.nop) begin
                        pc_write  = 1'b1;
                        inst_done = 1'b1;
                        w_next    = S_IF;
                    end else begin
                        w_next = S_EX;
                    end
                end
                S_EX: begin
                    alu_src_a = 1'b1;
                    if (w_cls.branch) begin
                        pc_write  = 1'b1;
                        pc_source = bcond ? PCS_BRANCH : PCS_PC1;
                        inst_done = 1'b1;
                        w_next    = S_IF;
                    end else if (w_cls.alu_r) begin
                        alu_src_b = ALUB_REG;
                        w_next    = S_WB;
                    end else if (w_cls.alu_i) begin
                        alu_src_b = ALUB_IMM;
                        w_next    = S_WB;
                    end else begin
                        alu_src_b = ALUB_IMM;
                        w_next    = S_MEM;
                    end
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = w_cls.lwd;
                    mem_write = w_cls.swd;
                    if (mem_ready) begin
                        if (w_cls.swd) begin
                            pc_write  = 1'b1;
                            inst_done = 1'b1;
                            w_next    = S_IF;
                        end else begin
                            w_next = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dest   = w_cls.alu_r ? RDST_RD : RDST_RT;
                    mem_to_reg = w_cls.lwd;
                    pc_write   = 1'b1;
                    inst_done  = 1'b1;
                    w_next     = S_IF;
                end
                S_HALT: begin
                    is_halted = 1'b1;
                end
                default: begin
                    w_next = S_IF;
                end
            endcase
        end
    end

`ifdef MC_CONTROL_NUM_INST_EN
    logic [WORD_SIZE-1:0] r_num_inst;

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_num_inst <= '0;
        else if (inst_done)
            r_num_inst <= r_num_inst + WORD_SIZE'(1);
    end

    assign num_inst = r_num_inst;
`endif

endmodule
